hazard_stall_ctrl: RTL and testbench

//  Stall/flush controller for the 5-stage MIPS pipeline; drives the F/D pipeline register
//  (F_D_RegWE, F_D_clear), PC write-enable and D/E bubble insertion.

---
 rtl/hazard_stall_ctrl_pkg.sv | 22 ++
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 36 +++
 rtl/hazard_stall_ctrl.sv | 84 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: field widths,
// the "operand unused" Tuse code, default HI/LO latencies and the RAW check.
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned T_W   = 2;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // A source stalls when an older instruction writes it and its value is not
  // ready by the time D needs it; register 0 and unused operands never stall.
  function automatic logic raw_hazard(input logic [REG_W-1:0] src,
                                      input logic [T_W-1:0]   tuse,
                                      input logic [REG_W-1:0] dst,
                                      input logic [T_W-1:0]   tnew);
    return (src != '0) && (src == dst) && (tuse != TUSE_NONE) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// HI/LO unit busy tracker: loads the op latency on a start pulse and counts
// down to zero; busy covers the start cycle plus the loaded number of cycles.
module hazard_stall_ctrl_md_busy_counter #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = reset & (start | (cnt_q != '0));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (Tuse/Tnew RAW + HI/LO busy).
// Define STALL_STATS_EN to add the stall_cnt statistics port and counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
`ifdef STALL_STATS_EN
  ,
  parameter int unsigned STAT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic [T_W-1:0]   D_Tuse_rs,
  input  logic [T_W-1:0]   D_Tuse_rt,
  input  logic             D_is_md,
  input  logic             D_flush_req,
  input  logic [REG_W-1:0] E_A3,
  input  logic [REG_W-1:0] M_A3,
  input  logic [T_W-1:0]   E_Tnew,
  input  logic [T_W-1:0]   M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  output logic             PC_WE,
  output logic             F_D_RegWE,
  output logic             F_D_clear,
  output logic             D_E_clear,
  output logic             md_busy
`ifdef STALL_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  logic stall_rs, stall_rt, stall_md, stall;

  hazard_stall_ctrl_md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_div),
    .busy   (md_busy)
  );

  assign stall_rs = raw_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew) |
                    raw_hazard(D_rs, D_Tuse_rs, M_A3, M_Tnew);
  assign stall_rt = raw_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew) |
                    raw_hazard(D_rt, D_Tuse_rt, M_A3, M_Tnew);
  assign stall_md = D_is_md & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  // In reset the pipe is frozen with a bubble held in D/E.
  always_comb begin
    PC_WE     = 1'b0;
    F_D_RegWE = 1'b0;
    F_D_clear = 1'b0;
    D_E_clear = 1'b1;
    if (reset && !stall) begin
      PC_WE     = 1'b1;
      F_D_RegWE = 1'b1;
      F_D_clear = D_flush_req;
      D_E_clear = 1'b0;
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: table of RAW/flush vectors plus
// hand-written HI/LO busy and reset sequences (stall_cnt with STALL_STATS_EN).
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_is_md, D_flush_req, E_md_start, E_md_div;
  logic       PC_WE, F_D_RegWE, F_D_clear, D_E_clear, md_busy;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_Tuse_rs   (D_Tuse_rs),
    .D_Tuse_rt   (D_Tuse_rt),
    .D_is_md     (D_is_md),
    .D_flush_req (D_flush_req),
    .E_A3        (E_A3),
    .M_A3        (M_A3),
    .E_Tnew      (E_Tnew),
    .M_Tnew      (M_Tnew),
    .E_md_start  (E_md_start),
    .E_md_div    (E_md_div),
    .PC_WE       (PC_WE),
    .F_D_RegWE   (F_D_RegWE),
    .F_D_clear   (F_D_clear),
    .D_E_clear   (D_E_clear),
    .md_busy     (md_busy)
`ifdef STALL_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs, rt, e_a3, m_a3;
    logic [1:0] tu_rs, tu_rt, e_tn, m_tn;
    logic       flush;
    logic [3:0] exp; // {PC_WE, F_D_RegWE, F_D_clear, D_E_clear}
  } vec_t;

  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1110;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] tu_rs,
                              input logic [4:0] rt, input logic [1:0] tu_rt,
                              input logic [4:0] e_a3, input logic [1:0] e_tn,
                              input logic [4:0] m_a3, input logic [1:0] m_tn,
                              input logic flush, input logic [3:0] exp);
    vec_t v;
    v.rs = rs; v.tu_rs = tu_rs; v.rt = rt; v.tu_rt = tu_rt;
    v.e_a3 = e_a3; v.e_tn = e_tn; v.m_a3 = m_a3; v.m_tn = m_tn;
    v.flush = flush; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic [3:0] exp);
    chk(name, {28'd0, PC_WE, F_D_RegWE, F_D_clear, D_E_clear}, {28'd0, exp});
  endtask

  task automatic idle_inputs();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
    E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0;
    D_is_md = 0; D_flush_req = 0; E_md_start = 0; E_md_div = 0;
  endtask

  // Start an md op, then hold an md instruction in D: busy and stall for n
  // cycles after the start cycle, then release.
  task automatic md_seq(input logic div, input int n);
    @(negedge clk);
    E_md_start = 1; E_md_div = div; D_is_md = 0;
    #2 chk("md_start_busy", {31'd0, md_busy}, 32'd1);
    chk_ctl("md_start_ctl", RUN);
    @(negedge clk);
    E_md_start = 0; E_md_div = 0; D_is_md = 1;
    for (int i = 1; i <= n + 1; i++) begin
      #2;
      chk($sformatf("md_busy_c%0d", i), {31'd0, md_busy}, {31'd0, (i <= n)});
      chk_ctl($sformatf("md_ctl_c%0d", i), (i <= n) ? STALL : RUN);
      @(negedge clk);
    end
    D_is_md = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    #2;
    chk_ctl("reset_ctl", STALL);
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    @(negedge clk);
    reset = 1;
    #2 chk_ctl("release_ctl", RUN);

    //          rs  tu  rt  tu  eA3 eTn mA3 mTn fl  exp
    vecs[0]  = mk(8, 0, 0, 3,  8, 2,  0, 0, 0, STALL);
    vecs[1]  = mk(8, 2, 0, 3,  8, 2,  0, 0, 0, RUN);
    vecs[2]  = mk(8, 1, 0, 3,  8, 2,  0, 0, 0, STALL);
    vecs[3]  = mk(0, 3, 9, 0,  0, 0,  9, 1, 0, STALL);
    vecs[4]  = mk(0, 3, 9, 1,  0, 0,  9, 1, 0, RUN);
    vecs[5]  = mk(0, 0, 0, 0,  0, 2,  0, 1, 0, RUN);
    vecs[6]  = mk(8, 3, 0, 3,  8, 2,  0, 0, 0, RUN);
    vecs[7]  = mk(1, 0, 0, 3,  2, 2,  0, 0, 1, FLUSH);
    vecs[8]  = mk(8, 0, 0, 3,  8, 2,  0, 0, 1, STALL);
    vecs[9]  = mk(0, 3, 5, 0,  5, 0,  0, 0, 0, RUN);
    vecs[10] = mk(7, 0, 0, 3,  7, 0,  7, 1, 0, STALL);
    vecs[11] = mk(3, 1, 3, 1,  3, 2,  0, 0, 0, STALL);

    foreach (vecs[i]) begin
      @(negedge clk);
      D_rs = vecs[i].rs; D_Tuse_rs = vecs[i].tu_rs;
      D_rt = vecs[i].rt; D_Tuse_rt = vecs[i].tu_rt;
      E_A3 = vecs[i].e_a3; E_Tnew = vecs[i].e_tn;
      M_A3 = vecs[i].m_a3; M_Tnew = vecs[i].m_tn;
      D_flush_req = vecs[i].flush;
      #2 chk_ctl($sformatf("vec%0d", i), vecs[i].exp);
    end
    @(negedge clk);
    idle_inputs();

    md_seq(1'b0, 5);
    md_seq(1'b1, 10);

    // Reset four cycles into a divide discards it.
    @(negedge clk);
    E_md_start = 1; E_md_div = 1;
    @(negedge clk);
    E_md_start = 0; E_md_div = 0; D_is_md = 1;
    repeat (3) @(negedge clk);
    #2 chk("div_busy_c4", {31'd0, md_busy}, 32'd1);
    reset = 0;
    #1 chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    chk_ctl("rst_mid_ctl", STALL);
    @(negedge clk);
    reset = 1;
    #2 chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
    chk_ctl("post_rst_ctl", RUN);
    @(negedge clk);
    idle_inputs();

`ifdef STALL_STATS_EN
    @(negedge clk);
    reset = 0;
    #1 chk("stats_reset", stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1;
    D_rs = 8; D_Tuse_rs = 0; E_A3 = 8; E_Tnew = 2;
    repeat (3) @(negedge clk);
    idle_inputs();
    md_seq(1'b0, 5);
    #2 chk("stats_total", stall_cnt, 32'd8);
    reset = 0;
    #1 chk("stats_cleared", stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
